// File: rtl/dual_issue_ctrl.sv
// Registered dual-issue stage: resolves intra-pair and load-use hazards for the alpha/beta slots.
// Optional load-use scoreboard enabled by defining DUAL_ISSUE_LOADUSE_EN.
module dual_issue_ctrl #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_a_in,
  input  logic [31:0] inst_b_in,
  input  logic        in_valid,
  input  logic        hold,
  input  logic        flush,
  output logic        in_ready,
  output logic [1:0]  pc_adv,
  output logic [31:0] inst_a_out,
  output logic [31:0] inst_b_out,
  output logic        issue_valid
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  typedef struct packed {
    logic       wr;
    logic       rd1;
    logic       rd2;
    logic       ld;
    logic       ctl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t       d;
    logic [6:0] op;
    op    = i[6:0];
    d.rd  = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.wr  = (op != OP_ST) && (op != OP_BR) && (d.rd != 5'd0);
    d.rd1 = (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    d.rd2 = (op == OP_R) || (op == OP_ST) || (op == OP_BR);
    d.ld  = (op == OP_LD);
    d.ctl = (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
    return d;
  endfunction

  dec_t da, db;
  logic alpha_stall, beta_busy;
  logic raw, waw, squash;

  assign da = decode(inst_a_in);
  assign db = decode(inst_b_in);

`ifdef DUAL_ISSUE_LOADUSE_EN
  localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

  logic [2:0]      sb [NREG];
  logic [NREG-1:0] set_vec;

  always_comb begin
    alpha_stall = (da.rd1 && (sb[da.rs1] != '0)) || (da.rd2 && (sb[da.rs2] != '0));
    beta_busy   = (db.rd1 && (sb[db.rs1] != '0)) || (db.rd2 && (sb[db.rs2] != '0));
  end

  // rd != 0 in both terms keeps x0's counter permanently clear
  always_comb begin
    set_vec = '0;
    if (in_ready && da.ld && da.wr)
      set_vec[da.rd] = 1'b1;
    if (in_ready && !squash && db.ld && db.wr)
      set_vec[db.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++)
        sb[r] <= '0;
    end else if (!hold) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (set_vec[r])
          sb[r] <= LAT3;
        else if (sb[r] != '0)
          sb[r] <= sb[r] - 3'd1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{inst_a_in[31:25], inst_a_in[14:12],
                       inst_b_in[31:25], inst_b_in[14:12], db.ctl};
`else
  assign alpha_stall = 1'b0;
  assign beta_busy   = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{inst_a_in[31:25], inst_a_in[14:12], inst_a_in[24:15],
                       inst_b_in[31:25], inst_b_in[14:12],
                       da.rd1, da.rd2, da.ld, db.ld, db.ctl,
                       32'(LOAD_LAT), 32'(NREG)};
`endif

  always_comb begin
    raw    = da.wr && ((db.rd1 && (db.rs1 == da.rd)) || (db.rd2 && (db.rs2 == da.rd)));
    waw    = da.wr && db.wr && (da.rd == db.rd);
    squash = raw || waw || da.ctl || beta_busy;
  end

  always_comb begin
    in_ready = in_valid && !hold && !alpha_stall;
    if (!in_ready)
      pc_adv = 2'd0;
    else if (squash)
      pc_adv = 2'd1;
    else
      pc_adv = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_a_out  <= NOP;
      inst_b_out  <= NOP;
      issue_valid <= 1'b0;
    end else if (!hold) begin
      if (flush || !in_ready) begin
        inst_a_out  <= NOP;
        inst_b_out  <= NOP;
        issue_valid <= 1'b0;
      end else begin
        inst_a_out  <= inst_a_in;
        inst_b_out  <= squash ? NOP : inst_b_in;
        issue_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: directed hazard cases plus random pairs against a
// reference model that tracks register readiness in units of non-held clock edges.
module tb_dual_issue_ctrl;
  localparam int          LL   = 2;
  localparam logic [31:0] NOPI = 32'h00000013;
`ifdef DUAL_ISSUE_LOADUSE_EN
  localparam int EXP_STALL = LL;
`else
  localparam int EXP_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_a_in, inst_b_in;
  logic        in_valid, hold, flush;
  logic        in_ready;
  logic [1:0]  pc_adv;
  logic [31:0] inst_a_out, inst_b_out;
  logic        issue_valid;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.LOAD_LAT(LL), .NREG(32), .NOP(NOPI)) dut (
    .clk(clk), .rst(rst), .inst_a_in(inst_a_in), .inst_b_in(inst_b_in),
    .in_valid(in_valid), .hold(hold), .flush(flush), .in_ready(in_ready),
    .pc_adv(pc_adv), .inst_a_out(inst_a_out), .inst_b_out(inst_b_out),
    .issue_valid(issue_valid)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   q[$];
  exp_t   m;
  longint ticks;
  longint ready_at[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [6:0] opc(input logic [31:0] i);
    return i[6:0];
  endfunction
  function automatic bit writes(input logic [31:0] i);
    return !(opc(i) == 7'h23 || opc(i) == 7'h63) && i[11:7] != 5'd0;
  endfunction
  function automatic bit reads1(input logic [31:0] i);
    return !(opc(i) == 7'h37 || opc(i) == 7'h17 || opc(i) == 7'h6f);
  endfunction
  function automatic bit reads2(input logic [31:0] i);
    return opc(i) == 7'h33 || opc(i) == 7'h23 || opc(i) == 7'h63;
  endfunction
  function automatic bit is_ld(input logic [31:0] i);
    return opc(i) == 7'h03;
  endfunction
  function automatic bit is_ctl(input logic [31:0] i);
    return opc(i) == 7'h63 || opc(i) == 7'h6f || opc(i) == 7'h67;
  endfunction
  function automatic bit busy(input logic [4:0] r);
`ifdef DUAL_ISSUE_LOADUSE_EN
    return ready_at[r] > ticks;
`else
    return r == 5'd31 && 1'b0;
`endif
  endfunction
  function automatic bit reads_busy(input logic [31:0] i);
    return (reads1(i) && busy(i[19:15])) || (reads2(i) && busy(i[24:20]));
  endfunction
  function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
    return (reads1(i) && i[19:15] == r) || (reads2(i) && i[24:20] == r);
  endfunction

  task automatic model_reset();
    m.a = NOPI; m.b = NOPI; m.v = 1'b0;
    ticks = 0;
    foreach (ready_at[i]) ready_at[i] = 0;
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic h, input logic f, output logic rdy);
    bit       er, sq;
    bit [1:0] eadv;
    @(negedge clk);
    inst_a_in = a; inst_b_in = b; in_valid = v; hold = h; flush = f;
    #1;
    er = v && !h && !reads_busy(a);
    sq = (writes(a) && reads_reg(b, a[11:7])) ||
         (writes(a) && writes(b) && a[11:7] == b[11:7]) ||
         is_ctl(a) || reads_busy(b);
    eadv = !er ? 2'd0 : (sq ? 2'd1 : 2'd2);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("pc_adv", 32'(pc_adv), 32'(eadv));
    rdy = in_ready;
    @(posedge clk);
    if (!h) begin
      if (f || !er) begin
        m.a = NOPI; m.b = NOPI; m.v = 1'b0;
      end else begin
        m.a = a; m.b = sq ? NOPI : b; m.v = 1'b1;
      end
      if (er && is_ld(a) && a[11:7] != 5'd0)
        ready_at[a[11:7]] = ticks + 1 + LL;
      if (er && !sq && is_ld(b) && b[11:7] != 5'd0)
        ready_at[b[11:7]] = ticks + 1 + LL;
      ticks++;
    end
    q.push_back(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_inst_a", inst_a_out, NOPI);
    chk("rst_inst_b", inst_b_out, NOPI);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h03};
    logic [31:0] i;
    i        = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // monitor: every pushed expectation is compared one half-cycle after its edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("inst_a_out", inst_a_out, e.a);
        chk("inst_b_out", inst_b_out, e.b);
        chk("issue_valid", 32'(issue_valid), 32'(e.v));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] LD  = 32'h00002283;
  localparam logic [31:0] DEP = 32'h00028333;

  initial begin
    logic r;
    int   stalls;
    model_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b1;
    inst_a_in = 32'h00500093; inst_b_in = 32'h00700113;
    #2;
    chk("reset_inst_a", inst_a_out, NOPI);
    chk("reset_inst_b", inst_b_out, NOPI);
    chk("reset_valid", 32'(issue_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_pc_adv", 32'(pc_adv), 32'd2);
    @(negedge clk);
    rst = 1'b0;

    cycle(32'h00500093, 32'h00700113, 1'b1, 1'b0, 1'b0, r);
    cycle(32'h00500093, 32'h002081B3, 1'b1, 1'b0, 1'b0, r);
    cycle(32'h00500093, 32'h00500093, 1'b1, 1'b0, 1'b0, r);
    cycle(32'h00000463, 32'h00700113, 1'b1, 1'b0, 1'b0, r);
    cycle(NOPI, NOPI, 1'b0, 1'b0, 1'b0, r);

    // load-use stall length
    cycle(LD, NOPI, 1'b1, 1'b0, 1'b0, r);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(DEP, NOPI, 1'b1, 1'b0, 1'b0, r);
      if (r) break;
      stalls++;
    end
    chk("loaduse_stalls", 32'(stalls), 32'(EXP_STALL));

    // hold in the middle of a stall freezes the countdown
    cycle(LD, NOPI, 1'b1, 1'b0, 1'b0, r);
    cycle(DEP, NOPI, 1'b1, 1'b0, 1'b0, r);
    stalls = r ? 0 : 1;
    repeat (3) cycle(DEP, NOPI, 1'b1, 1'b1, 1'b0, r);
    if (stalls != 0) begin
      for (int i = 0; i < 10; i++) begin
        cycle(DEP, NOPI, 1'b1, 1'b0, 1'b0, r);
        if (r) break;
        stalls++;
      end
    end
    chk("hold_stalls", 32'(stalls), 32'(EXP_STALL));

    // reset mid-stall
    cycle(LD, NOPI, 1'b1, 1'b0, 1'b0, r);
    cycle(DEP, NOPI, 1'b1, 1'b0, 1'b0, r);
    do_reset();
    cycle(DEP, NOPI, 1'b1, 1'b0, 1'b0, r);
    chk("post_reset_accept", 32'(r), 32'd1);

    // flush kills a captured pair
    cycle(32'h00500093, 32'h00700113, 1'b1, 1'b0, 1'b1, r);

    for (int i = 0; i < 600; i++)
      cycle(rnd_inst(), rnd_inst(), $urandom_range(0, 99) < 85,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5, r);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_issue_ctrl.md
# dual_issue_ctrl

Registered issue stage for the two-slot (alpha/beta) RV32I datapath. Accepts a fetched instruction pair, resolves intra-pair hazards (RAW, WAW, control) and load-use hazards against a per-register scoreboard, and presents a hazard-free pair to `ctrl_datapath`. It reports how far the fetch PC advances (0, +4 or +8).

## Interface
- `LOAD_LAT`, 2: cycles a load destination stays busy after issue (1..7).
- `NREG`, 32: architectural register count. Register index width is fixed at 5.
- `NOP`, 32'h00000013: instruction substituted into a squashed slot.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_a_in`  in  32  older fetched instruction (alpha slot).
- `inst_b_in`  in  32  younger fetched instruction (beta slot).
- `in_valid`  in  1  the fetched pair is valid.
- `hold`  in  1  downstream stall. While high, freezes all state.
- `flush`  in  1  kills the issue register contents.
- `in_ready`  out  1  the pair is accepted this cycle (combinational).
- `pc_adv`  out  2  fetch PC advance: 0 = none, 1 = +4, 2 = +8 (combinational).
- `inst_a_out`  out  32  issued alpha instruction (registered).
- `inst_b_out`  out  32  issued beta instruction (registered).
- `issue_valid`  out  1  the output pair is valid (registered).

## Operation
- Decode, by opcode [6:0]:
  - Writes rd: opcode not in {0100011, 1100011} and rd != 0.
  - Reads rs1: opcode not in {0110111, 0010111, 1101111}.
  - Reads rs2: opcode in {0110011, 0100011, 1100011}.
  - Load: opcode 0000011.
  - Control: opcode in {1100011, 1101111, 1100111}.
- Alpha stall: alpha reads a register whose scoreboard counter is nonzero. Then `in_ready=0` and `pc_adv=0`.
- Beta squash. Any of the following squashes beta (beta issues as `NOP`, `pc_adv=1`):
  - alpha writes rd and beta reads that rd;
  - alpha and beta write the same rd;
  - alpha is a control instruction;
  - beta reads a busy scoreboard register.
- Otherwise `pc_adv=2`.
- Ready rule: `in_ready = in_valid & !hold & !alpha_stall`.
- Idle: `pc_adv=0` whenever `in_ready=0`.
- Capture, when `!hold`:
  - If `in_ready`: output registers take the (possibly squashed) pair, and `issue_valid=1`.
  - Else: outputs become `NOP`/`NOP`, and `issue_valid=0`.
- Scoreboard: one counter per register, width 3.
  - When `!hold`, every nonzero counter decrements.
  - Then each issued (non-squashed) load with rd != 0 sets its counter to `LOAD_LAT`. A set wins over a decrement.
  - Counter 0 (x0) is never set.
- Flush, when `!hold`: outputs become `NOP`/`NOP` and `issue_valid=0`, overriding capture. The scoreboard is not cleared (conservative; costs at most `LOAD_LAT` extra stall cycles).
- Hold: no register changes, including counters. `flush` is ignored while `hold` is high.

## Timing
- Reset values:
  - `inst_a_out=inst_b_out=NOP`, `issue_valid=0`.
  - All counters 0.
  - Hence `in_ready=in_valid`, and `pc_adv` equals the intra-pair result.
- Latency: a pair accepted at edge t appears on the outputs after edge t.
- Load-use: a load issued at edge t blocks a dependent alpha until its counter reaches 0. The dependent is accepted at edge t+`LOAD_LAT`+1, given no `hold`.
- Reset mid-stall clears the counters. The pending pair is accepted in the first cycle after release.
- `pc_adv` and `in_ready` settle combinationally within the same cycle as `inst_*_in`. The fetch PC must update only when `in_ready=1`.

## Configuration
- `DUAL_ISSUE_LOADUSE_EN` defined: scoreboard present, with load-use stall/squash as above.
- Not defined:
  - No scoreboard registers.
  - Alpha never stalls: `in_ready = in_valid & !hold`.
  - Only the intra-pair rules apply.
  - `LOAD_LAT` is unused.

## Test plan
- Independent pair: 0x00500093 / 0x00700113 → `pc_adv=2`; after the edge, outputs equal the inputs with `issue_valid=1`.
- RAW pair: 0x00500093 / 0x002081B3 → `pc_adv=1`, `inst_b_out=0x00000013`. A 0x00500093 / 0x00500093 (WAW) pair gives the same result.
- Control: 0x00000463 / 0x00700113 → `pc_adv=1`, beta issued as `NOP`.
- Load-use with `DUAL_ISSUE_LOADUSE_EN` and `LOAD_LAT=2`:
  - Send pair 0x00002283 / 0x00000013, then pair 0x00028333 / 0x00000013.
  - Required: `in_ready=0` for 2 cycles with `issue_valid=0` outputs, then acceptance with `pc_adv=2`.
  - Without the macro: accepted immediately.
- `hold` asserted for 3 cycles during a load-use stall → outputs and counters frozen. The stall resumes where it left off.
- `rst` pulsed mid-stall → outputs `NOP`/`NOP`, `issue_valid=0` immediately. The next cycle after release accepts the pair.
